// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single main-memory port between the I-cache refill and the
// D-cache refill/write-back paths. Each granted block is moved word by word
// against a fixed-latency memory. MemBusy lets the hazard unit stall the pipe.
module cache_mem_arbiter #(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned WORDS   = 4
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       IReq,
  input  logic [31:0]                IAddr,
  output logic                       IGnt,
  output logic                       IValid,
  output logic [31:0]                IRData,
  output logic [$clog2(WORDS)-1:0]   IWordIdx,
  output logic                       IDone,
  input  logic                       DReq,
  input  logic                       DWrite,
  input  logic [31:0]                DAddr,
  input  logic [31:0]                DWData,
  output logic                       DGnt,
  output logic                       DValid,
  output logic [31:0]                DRData,
  output logic [$clog2(WORDS)-1:0]   DWordIdx,
  output logic                       DDone,
  output logic [31:0]                MemAddr,
  output logic                       MemRead,
  output logic                       MemWrite,
  output logic [31:0]                MemWData,
  input  logic [31:0]                MemRData,
  output logic                       MemBusy
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WORDS - 1);
  localparam logic [31:0]      BASE_MASK  = ~((32'd1 << (IDX_W + 2)) - 32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             lastd_q, lastd_d;
  // Side of the block currently owned: 1 = D-cache, 0 = I-cache.
  logic             side_q, side_d;

  logic i_act, d_act, xfer, beat;

  assign i_act = (state_q == I_XFER);
  assign d_act = (state_q == D_XFER);
  assign xfer  = i_act | d_act;
  assign beat  = xfer & (cnt_q == '0);

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      lastd_q <= 1'b0;
      side_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      lastd_q <= lastd_d;
      side_q  <= side_d;
    end
  end

  // Next-state: round-robin grant in IDLE, word/latency sequencing in XFER.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    lastd_d = lastd_q;
    side_d  = side_q;
    unique case (state_q)
      IDLE: begin
        if (DReq && (!IReq || !lastd_q)) begin
          state_d = D_XFER;
          side_d  = 1'b1;
          base_d  = DAddr & BASE_MASK;
          wr_d    = DWrite;
          idx_d   = '0;
          cnt_d   = CNT_RELOAD;
        end else if (IReq) begin
          state_d = I_XFER;
          side_d  = 1'b0;
          base_d  = IAddr & BASE_MASK;
          wr_d    = 1'b0;
          idx_d   = '0;
          cnt_d   = CNT_RELOAD;
        end
      end
      I_XFER, D_XFER: begin
        if (cnt_q == '0) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = CNT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        lastd_d = side_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is derived from registered state so reset
  // clears all outputs at once. Base has its low bits cleared, so the word
  // offset is OR-ed in rather than added.
  always_comb begin
    MemBusy  = (state_q != IDLE);
    IGnt     = i_act | ((state_q == DONE) & ~side_q);
    DGnt     = d_act | ((state_q == DONE) &  side_q);
    IDone    = (state_q == DONE) & ~side_q;
    DDone    = (state_q == DONE) &  side_q;
    IValid   = i_act & beat;
    DValid   = d_act & beat;
    IRData   = IValid ? MemRData : '0;
    DRData   = (DValid & ~wr_q) ? MemRData : '0;
    IWordIdx = i_act ? idx_q : '0;
    DWordIdx = d_act ? idx_q : '0;
    MemAddr  = xfer ? (base_q | (32'(idx_q) << 2)) : '0;
    MemRead  = xfer & ~wr_q;
    MemWrite = xfer &  wr_q;
    MemWData = (d_act & wr_q) ? DWData : '0;
  end

endmodule
